// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response stream and APB3 signals of the bridge
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB3 initiator with PREADY wait-timeout
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic PCLK,
  input  logic PRESET,
  apb_master_bridge_if.master bus
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic expire, accept, finish;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    expire   = 1'b0;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        accept   = bus.cmd_valid && bus.cmd_ready;
        state_nx = accept ? SETUP : IDLE;
      end
      SETUP: begin
        cnt_nx   = '0;
        state_nx = ACCESS;
      end
      ACCESS: begin
        cnt_nx   = bus.PREADY ? cnt : (cnt == '1 ? cnt : cnt + 1'b1);
        expire   = (TIMEOUT_CYCLES > 0) && !bus.PREADY && (cnt == LAST);
        finish   = bus.PREADY || expire;
        state_nx = finish ? RESP : ACCESS;
      end
      default: state_nx = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
  // outputs are registered from the next state so they change with the state itself
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= {ADDR_WIDTH{1'b0}};
      bus.PWDATA      <= {DATA_WIDTH{1'b0}};
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= {DATA_WIDTH{1'b0}};
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      bus.cmd_ready <= state_nx == IDLE;
      bus.PSEL      <= state_nx == SETUP || state_nx == ACCESS;
      bus.PENABLE   <= state_nx == ACCESS;
      bus.rsp_valid <= state_nx == RESP;
      if (accept) begin
        bus.PWRITE <= bus.cmd_write;
        bus.PADDR  <= bus.cmd_addr;
        bus.PWDATA <= bus.cmd_wdata;
      end
      if (finish) begin
        bus.rsp_rdata   <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : {DATA_WIDTH{1'b0}};
        bus.rsp_err     <= bus.PREADY ? bus.PSLVERR : 1'b1;
        bus.rsp_timeout <= !bus.PREADY;
      end
    end
  end
endmodule
